// File: rtl/irq_source_ctrl_pkg.sv
// irq_source_ctrl_pkg
//  Shared defaults for the external interrupt source front end. Board builds
//  override these through the parameters of irq_source_ctrl. NIRQ and
//  NBIT_IRQ have to match the core's irq_src width and interrupt number width.
package irq_source_ctrl_pkg;

  localparam int IRQ_NIRQ      = 3;   // request lines == core irq_src width
  localparam int IRQ_NBIT_IRQ  = 2;   // ceil(log2(IRQ_NIRQ))
  localparam int IRQ_DB_CYCLES = 16;  // stable cycles needed to accept a level change
  localparam int IRQ_DB_NBIT   = 5;   // 2**IRQ_DB_NBIT > IRQ_DB_CYCLES

endpackage

// File: rtl/irq_debounce.sv
// irq_debounce
//  One request line: 2-FF synchronizer, stability counter and debounced
//  level FF. A new level is accepted only after the synchronized input has
//  differed from the current level for DB_CYCLES consecutive edges. Any
//  return to the current level restarts the count, which drops short glitches.
// Ports
//  clk    in   1  core clock
//  rst_n  in   1  asynchronous reset, active low
//  raw    in   1  raw asynchronous request, active high
//  level  out  1  debounced level, registered
//  rise   out  1  high in the cycle whose edge takes level from 0 to 1
module irq_debounce
  import irq_source_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = IRQ_DB_CYCLES,
  parameter int DB_NBIT   = IRQ_DB_NBIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [DB_NBIT-1:0] CNT_LAST = DB_NBIT'(DB_CYCLES - 1);

  logic               s1;
  logic               s2;
  logic [DB_NBIT-1:0] cnt;
  logic               accept;

  // Level changes at the next edge when the mismatch has lasted long enough.
  assign accept = (s2 != level) && (cnt == CNT_LAST);
  // Same-cycle rise lets the parent set the pending bit on the very edge
  // that raises level, so both become visible together.
  assign rise   = accept && s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_source_ctrl.sv
// irq_source_ctrl
//  Front end for external interrupt requests (board buttons). Each line is
//  synchronized and debounced; a debounced 0->1 edge sets a pending bit that
//  is held until the core acknowledges entry to that line's handler.
//  Prioritisation and IE masking are left to the C0 unit.
// Ports
//  clk        in   1         core clock, single domain
//  rst_n      in   1         asynchronous reset, active low
//  en         in   1         core enable; gates acknowledge only
//  btn_raw    in   NIRQ      raw asynchronous request lines, active high
//  ack        in   1         core entered a handler this cycle
//  ack_inum   in   NBIT_IRQ  interrupt number being entered, valid with ack
//  irq_src    out  NIRQ      pending requests to the core, registered
//  dbg_level  out  NIRQ      debounced level per line, registered
module irq_source_ctrl
  import irq_source_ctrl_pkg::*;
#(
  parameter int NIRQ      = IRQ_NIRQ,
  parameter int NBIT_IRQ  = IRQ_NBIT_IRQ,
  parameter int DB_CYCLES = IRQ_DB_CYCLES,
  parameter int DB_NBIT   = IRQ_DB_NBIT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [NIRQ-1:0]     btn_raw,
  input  logic                ack,
  input  logic [NBIT_IRQ-1:0] ack_inum,
  output logic [NIRQ-1:0]     irq_src,
  output logic [NIRQ-1:0]     dbg_level
);

  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] clr;
  logic [NIRQ-1:0] pend_nxt;

  for (genvar i = 0; i < NIRQ; i++) begin : g_line
    irq_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .DB_NBIT   (DB_NBIT)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_raw[i]),
      .level (dbg_level[i]),
      .rise  (rise[i])
    );

    // Only indices 0..NIRQ-1 can match, so out-of-range numbers clear nothing.
    assign clr[i] = en && ack && (ack_inum == NBIT_IRQ'(i));
  end

  // Set has priority over clear: an edge arriving while its handler is
  // being entered must be serviced again, so it is never swallowed.
  always_comb begin
    pend_nxt = (irq_src & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_src <= '0;
    else        irq_src <= pend_nxt;
  end

endmodule

// File: tb/tb_irq_source_ctrl.sv
module tb_irq_source_ctrl;

  localparam int NIRQ = 3;
  localparam int NBIT_IRQ = 2;
  localparam int DB_CYCLES = 4;
  localparam int DB_NBIT = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic [NIRQ-1:0]     btn_raw = '0;
  logic                ack = 1'b0;
  logic [NBIT_IRQ-1:0] ack_inum = '0;
  logic [NIRQ-1:0]     irq_src;
  logic [NIRQ-1:0]     dbg_level;

  int checks = 0;
  int passed = 0;

  irq_source_ctrl #(
    .NIRQ      (NIRQ),
    .NBIT_IRQ  (NBIT_IRQ),
    .DB_CYCLES (DB_CYCLES),
    .DB_NBIT   (DB_NBIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .btn_raw   (btn_raw),
    .ack       (ack),
    .ack_inum  (ack_inum),
    .irq_src   (irq_src),
    .dbg_level (dbg_level)
  );

  always #5 clk = ~clk;

  // One active edge, then park on the falling edge for sampling/driving.
  task automatic tick(input int n);
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    btn_raw = 3'b111;
    rst_n   = 1'b0;
    tick(3);
    checks++;
    if (irq_src !== 3'b000) $display("FAIL reset_irq_src got %b want 000", irq_src);
    else passed++;
    checks++;
    if (dbg_level !== 3'b000) $display("FAIL reset_dbg_level got %b want 000", dbg_level);
    else passed++;
    rst_n = 1'b1;
    tick(5);  // edges k..k+4
    checks++;
    if (irq_src !== 3'b000) $display("FAIL reset_early got %b want 000", irq_src);
    else passed++;
    tick(1);  // edge k+5
    checks++;
    if (irq_src !== 3'b111) $display("FAIL reset_event got %b want 111", irq_src);
    else passed++;
    checks++;
    if (dbg_level !== 3'b111) $display("FAIL reset_level got %b want 111", dbg_level);
    else passed++;
    // Clear all three; a held line must not re-raise them.
    en = 1'b1; ack = 1'b1;
    for (int i = 0; i < NIRQ; i++) begin
      ack_inum = NBIT_IRQ'(i);
      tick(1);
    end
    ack = 1'b0;
    tick(10);
    checks++;
    if (irq_src !== 3'b000) $display("FAIL reset_single_event got %b want 000", irq_src);
    else passed++;
  endtask

  task automatic test_latency;
    btn_raw = 3'b000;
    tick(10);
    checks++;
    if (dbg_level !== 3'b000 || irq_src !== 3'b000)
      $display("FAIL fall_no_event got lvl=%b src=%b want 000/000", dbg_level, irq_src);
    else passed++;
    btn_raw[1] = 1'b1;
    tick(5);  // edges k..k+4
    checks++;
    if (irq_src !== 3'b000 || dbg_level !== 3'b000)
      $display("FAIL latency_early got src=%b lvl=%b want 000/000", irq_src, dbg_level);
    else passed++;
    tick(1);  // edge k+5
    checks++;
    if (irq_src !== 3'b010) $display("FAIL latency_src got %b want 010", irq_src);
    else passed++;
    checks++;
    if (dbg_level !== 3'b010) $display("FAIL latency_level got %b want 010", dbg_level);
    else passed++;
  endtask

  task automatic test_glitch;
    logic seen;
    seen = 1'b0;
    btn_raw[0] = 1'b1;
    tick(3);
    btn_raw[0] = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick(1);
      if (irq_src[0] !== 1'b0 || dbg_level[0] !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL glitch_dropped got seen=%b want 0", seen);
    else passed++;
    checks++;
    if (irq_src !== 3'b010) $display("FAIL glitch_src got %b want 010", irq_src);
    else passed++;
  endtask

  task automatic test_ack;
    btn_raw[0] = 1'b1;
    tick(6);
    checks++;
    if (irq_src !== 3'b011) $display("FAIL ack_setup got %b want 011", irq_src);
    else passed++;
    en = 1'b0; ack = 1'b1; ack_inum = 2'd1;
    tick(1);
    checks++;
    if (irq_src !== 3'b011) $display("FAIL ack_en0 got %b want 011", irq_src);
    else passed++;
    en = 1'b1; ack_inum = 2'd3;
    tick(1);
    checks++;
    if (irq_src !== 3'b011) $display("FAIL ack_out_of_range got %b want 011", irq_src);
    else passed++;
    ack_inum = 2'd2;
    tick(1);
    checks++;
    if (irq_src !== 3'b011) $display("FAIL ack_not_pending got %b want 011", irq_src);
    else passed++;
    ack_inum = 2'd1;
    tick(1);
    checks++;
    if (irq_src !== 3'b001) $display("FAIL ack_clear got %b want 001", irq_src);
    else passed++;
    ack = 1'b0;
  endtask

  task automatic test_collision;
    btn_raw[2] = 1'b1;
    tick(5);  // edges k..k+4
    checks++;
    if (irq_src !== 3'b001) $display("FAIL collide_early got %b want 001", irq_src);
    else passed++;
    en = 1'b1; ack = 1'b1; ack_inum = 2'd2;
    tick(1);  // edge k+5: rise and ack together
    checks++;
    if (irq_src !== 3'b101) $display("FAIL collide_set_wins got %b want 101", irq_src);
    else passed++;
    ack = 1'b0;
    tick(1);
    checks++;
    if (irq_src !== 3'b101) $display("FAIL collide_hold got %b want 101", irq_src);
    else passed++;
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    checks++;
    if (irq_src !== 3'b001) $display("FAIL collide_later_ack got %b want 001", irq_src);
    else passed++;
  endtask

  task automatic test_mid_reset;
    btn_raw = 3'b000;
    tick(10);
    btn_raw[0] = 1'b1;
    tick(4);  // edges k..k+3: line 0 counter now 2
    checks++;
    if (irq_src !== 3'b001) $display("FAIL midrst_before got %b want 001", irq_src);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (irq_src !== 3'b000 || dbg_level !== 3'b000)
      $display("FAIL midrst_async got src=%b lvl=%b want 000/000", irq_src, dbg_level);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick(5);  // fresh count from edge j: j..j+4
    checks++;
    if (irq_src !== 3'b000) $display("FAIL midrst_restart_early got %b want 000", irq_src);
    else passed++;
    tick(1);
    checks++;
    if (irq_src !== 3'b001) $display("FAIL midrst_restart_event got %b want 001", irq_src);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_ack();
    test_collision();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
